// File: rtl/posit_normalise_pipe.sv
// posit_normalise_pipe: two-stage normaliser between the posit adder core and
// the posit encoder. Stage 1 counts leading zeros and folds regime/exponent
// into one signed scale; stage 2 shifts the fraction up to the leading one and
// splits the corrected scale back into regime and exponent.
// Optional feature: define NORMALISE_SAT_EN to clamp the regime to the legal
// posit range [-(NBITS-1), NBITS-2] and raise sat; otherwise the regime wraps.
module posit_normalise_pipe #(
    parameter int WIDTH = 8,
    parameter int ES    = 1,
    parameter int NBITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    mantissa_sum,
    input  logic signed [7:0]   in_regime,
    input  logic [ES-1:0]       in_exponent,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-2:0]    mantissa,
    output logic signed [7:0]   regime,
    output logic [ES-1:0]       exponent,
    output logic                zero,
    output logic                sat
);

    localparam int LZW = $clog2(WIDTH + 1);
    localparam int SW  = 8 + ES + 2;

`ifdef NORMALISE_SAT_EN
    localparam logic signed [SW-1:0] RMAX_S = SW'(NBITS - 2);
    localparam logic signed [SW-1:0] RMIN_S = SW'(1 - NBITS);
`endif

    // Stage 1 registers
    logic                 s1_v_q,     s1_v_d;
    logic [LZW-1:0]       s1_lz_q,    s1_lz_d;
    logic [WIDTH-1:0]     s1_mant_q,  s1_mant_d;
    logic signed [SW-1:0] s1_scale_q, s1_scale_d;

    // Stage 2 (output) registers
    logic                 s2_v_q,     s2_v_d;
    logic [WIDTH-2:0]     mantissa_q, mantissa_d;
    logic signed [7:0]    regime_q,   regime_d;
    logic [ES-1:0]        exponent_q, exponent_d;
    logic                 zero_q,     zero_d;
`ifdef NORMALISE_SAT_EN
    logic                 sat_q,      sat_d;
`endif

    logic                 s1_load;
    logic                 s2_load;
    logic signed [SW-1:0] s_prime;

    // Stage 2 can take a beat when it is empty or its beat leaves this cycle;
    // stage 1 can take one when it is empty or stage 2 drains it.
    assign s2_load  = !s2_v_q || out_ready;
    assign s1_load  = !s1_v_q || s2_load;
    assign in_ready = s1_load;

    // Stage 1: leading-zero count and combined scale; data only captured on a real beat
    always_comb begin
        s1_v_d     = s1_v_q;
        s1_lz_d    = s1_lz_q;
        s1_mant_d  = s1_mant_q;
        s1_scale_d = s1_scale_q;
        if (s1_load) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_lz_d = LZW'(WIDTH);
                for (int i = 0; i < WIDTH; i++) begin
                    if (mantissa_sum[i]) begin
                        s1_lz_d = LZW'(WIDTH - 1 - i);
                    end
                end
                s1_mant_d  = mantissa_sum;
                s1_scale_d = (SW'(in_regime) <<< ES) + SW'(in_exponent);
            end
        end
    end

    // Corrected scale: a carry (lz=0) adds one, cancellation subtracts lz-1
    assign s_prime = s1_scale_q + SW'(1) - SW'(s1_lz_q);

    // Stage 2: renormalise the fraction, split the scale, apply zero and clamp rules
    always_comb begin
        s2_v_d     = s2_v_q;
        mantissa_d = mantissa_q;
        regime_d   = regime_q;
        exponent_d = exponent_q;
        zero_d     = zero_q;
`ifdef NORMALISE_SAT_EN
        sat_d      = sat_q;
`endif
        if (s2_load) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                // Shifting by lz and dropping the top bit equals shifting by
                // lz+1 and keeping the upper WIDTH-1 bits: the hidden one goes.
                mantissa_d = (WIDTH-1)'(s1_mant_q << s1_lz_q);
                regime_d   = 8'(s_prime >>> ES);
                exponent_d = s_prime[ES-1:0];
                zero_d     = 1'b0;
`ifdef NORMALISE_SAT_EN
                sat_d      = 1'b0;
                if ((s_prime >>> ES) > RMAX_S) begin
                    regime_d   = 8'(RMAX_S);
                    exponent_d = '1;
                    mantissa_d = '0;
                    sat_d      = 1'b1;
                end else if ((s_prime >>> ES) < RMIN_S) begin
                    regime_d   = 8'(RMIN_S);
                    exponent_d = '0;
                    mantissa_d = '0;
                    sat_d      = 1'b1;
                end
`endif
                if (s1_lz_q == LZW'(WIDTH)) begin
                    mantissa_d = '0;
                    regime_d   = 8'h80;
                    exponent_d = '0;
                    zero_d     = 1'b1;
`ifdef NORMALISE_SAT_EN
                    sat_d      = 1'b0;
`endif
                end
            end
        end
    end

    // Pipeline registers; reset discards any in-flight beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q     <= 1'b0;
            s1_lz_q    <= '0;
            s1_mant_q  <= '0;
            s1_scale_q <= '0;
            s2_v_q     <= 1'b0;
            mantissa_q <= '0;
            regime_q   <= '0;
            exponent_q <= '0;
            zero_q     <= 1'b0;
`ifdef NORMALISE_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            s1_v_q     <= s1_v_d;
            s1_lz_q    <= s1_lz_d;
            s1_mant_q  <= s1_mant_d;
            s1_scale_q <= s1_scale_d;
            s2_v_q     <= s2_v_d;
            mantissa_q <= mantissa_d;
            regime_q   <= regime_d;
            exponent_q <= exponent_d;
            zero_q     <= zero_d;
`ifdef NORMALISE_SAT_EN
            sat_q      <= sat_d;
`endif
        end
    end

    assign out_valid = s2_v_q;
    assign mantissa  = mantissa_q;
    assign regime    = regime_q;
    assign exponent  = exponent_q;
    assign zero      = zero_q;
`ifdef NORMALISE_SAT_EN
    assign sat       = sat_q;
`else
    assign sat       = 1'b0;
`endif

endmodule
